// File: rtl/hex_display_ctrl_if.sv
// Avalon-MM slave bus bundle for the seven-segment display controller.
interface hex_display_ctrl_if;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/hex_display_ctrl.sv
// Seven-segment display controller: per-digit hex decode or raw segments,
// blank and blink masks, global PWM brightness, Avalon-MM register access.
module hex_display_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000,
  parameter int PWM_BITS   = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  hex_display_ctrl_if.slave       bus,
  output logic [7*NUM_DIGITS-1:0] hex_out
);

  localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BCW-1:0]      BLINK_LAST = BCW'(BLINK_DIV - 1);
  localparam logic [PWM_BITS-1:0] PWM_LAST   = PWM_BITS'((1 << PWM_BITS) - 2);
  localparam logic [7*NUM_DIGITS-1:0] DARK_PINS =
    (ACTIVE_LOW != 0) ? {(7*NUM_DIGITS){1'b1}} : {(7*NUM_DIGITS){1'b0}};

  // Active-high g..a pattern for a hex nibble.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_decode = 7'h3F;
      4'h1:    hex_decode = 7'h06;
      4'h2:    hex_decode = 7'h5B;
      4'h3:    hex_decode = 7'h4F;
      4'h4:    hex_decode = 7'h66;
      4'h5:    hex_decode = 7'h6D;
      4'h6:    hex_decode = 7'h7D;
      4'h7:    hex_decode = 7'h07;
      4'h8:    hex_decode = 7'h7F;
      4'h9:    hex_decode = 7'h6F;
      4'hA:    hex_decode = 7'h77;
      4'hB:    hex_decode = 7'h7C;
      4'hC:    hex_decode = 7'h39;
      4'hD:    hex_decode = 7'h5E;
      4'hE:    hex_decode = 7'h79;
      4'hF:    hex_decode = 7'h71;
      default: hex_decode = 7'h00;
    endcase
  endfunction

  logic [4*NUM_DIGITS-1:0] data_r;
  logic [NUM_DIGITS-1:0]   mode_r;
  logic [NUM_DIGITS-1:0]   blank_r;
  logic [NUM_DIGITS-1:0]   blink_r;
  logic [PWM_BITS-1:0]     bright_r;
  logic [6:0]              raw_r [NUM_DIGITS];

  logic [BCW-1:0]          blink_cnt_r;
  logic                    phase_r;
  logic [PWM_BITS-1:0]     pwm_cnt_r;

  logic                    we_s;
  logic                    pwm_on_s;
  logic [7*NUM_DIGITS-1:0] next_hex_s;

  assign we_s     = bus.chipselect & ~bus.write_n;
  assign pwm_on_s = (pwm_cnt_r < bright_r);

  // Register file writes; out-of-range addresses fall through untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_r   <= {(4*NUM_DIGITS){1'b0}};
      mode_r   <= {NUM_DIGITS{1'b0}};
      blank_r  <= {NUM_DIGITS{1'b1}};
      blink_r  <= {NUM_DIGITS{1'b0}};
      bright_r <= {PWM_BITS{1'b1}};
      for (int i = 0; i < NUM_DIGITS; i++) raw_r[i] <= 7'h00;
    end else if (we_s) begin
      case (bus.address)
        4'd0: data_r   <= bus.writedata[4*NUM_DIGITS-1:0];
        4'd1: mode_r   <= bus.writedata[NUM_DIGITS-1:0];
        4'd2: blank_r  <= bus.writedata[NUM_DIGITS-1:0];
        4'd3: blink_r  <= bus.writedata[NUM_DIGITS-1:0];
        4'd4: bright_r <= bus.writedata[PWM_BITS-1:0];
        default: begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bus.address == 4'(8 + i)) raw_r[i] <= bus.writedata[6:0];
          end
        end
      endcase
    end
  end

  // Free-running blink divider and PWM counter, independent of bus writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_r <= {BCW{1'b0}};
      phase_r     <= 1'b0;
      pwm_cnt_r   <= {PWM_BITS{1'b0}};
    end else begin
      if (blink_cnt_r == BLINK_LAST) begin
        blink_cnt_r <= {BCW{1'b0}};
        phase_r     <= ~phase_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + 1'b1;
      end
      if (pwm_cnt_r == PWM_LAST) pwm_cnt_r <= {PWM_BITS{1'b0}};
      else                       pwm_cnt_r <= pwm_cnt_r + 1'b1;
    end
  end

  // Combine segment source, masks and brightness into next pin values.
  always_comb begin : compose
    logic [6:0] seg_v;
    logic [6:0] lit_v;
    logic       dark_v;
    next_hex_s = {(7*NUM_DIGITS){1'b0}};
    seg_v      = 7'h00;
    lit_v      = 7'h00;
    dark_v     = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (mode_r[i]) seg_v = raw_r[i];
      else           seg_v = hex_decode(data_r[4*i +: 4]);
      dark_v = blank_r[i] | (blink_r[i] & phase_r) | ~pwm_on_s;
      if (dark_v) lit_v = 7'h00;
      else        lit_v = seg_v;
      if (ACTIVE_LOW != 0) next_hex_s[7*i +: 7] = ~lit_v;
      else                 next_hex_s[7*i +: 7] = lit_v;
    end
  end

  // Single output register stage towards the board pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hex_out <= DARK_PINS;
    else          hex_out <= next_hex_s;
  end

  // Zero-wait-state read mux; chipselect is not needed to read.
  always_comb begin
    bus.readdata = 32'h0000_0000;
    case (bus.address)
      4'd0: bus.readdata = 32'(data_r);
      4'd1: bus.readdata = 32'(mode_r);
      4'd2: bus.readdata = 32'(blank_r);
      4'd3: bus.readdata = 32'(blink_r);
      4'd4: bus.readdata = 32'(bright_r);
      default: begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (bus.address == 4'(8 + i)) bus.readdata = {25'h0, raw_r[i]};
          else                          bus.readdata = bus.readdata;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl: cycle-level behavioural model
// plus directed literal checks.
module tb_hex_display_ctrl;
  localparam int ND  = 6;
  localparam int BD  = 4;
  localparam int PB  = 2;
  localparam int W   = 7 * ND;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] hex_out;

  hex_display_ctrl_if bus();

  hex_display_ctrl #(
    .NUM_DIGITS(ND), .BLINK_DIV(BD), .PWM_BITS(PB), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .hex_out(hex_out)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [6:0]  seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [31:0] m_reg [16];
  int          m_cyc;
  logic [W-1:0] exp_hex;

  function automatic logic [31:0] reg_mask(input logic [3:0] a);
    if (a == 4'd0)                   return 32'h00FF_FFFF;
    if (a >= 4'd1 && a <= 4'd3)      return 32'h0000_003F;
    if (a == 4'd4)                   return 32'h0000_0003;
    if (a >= 4'd8 && a <= 4'd13)     return 32'h0000_007F;
    return 32'h0;
  endfunction

  // Pins implied by the model registers with `cyc` clock edges since reset.
  function automatic logic [W-1:0] model_hex(input int cyc);
    logic [W-1:0] r = '0;
    for (int i = 0; i < ND; i++) begin
      logic [6:0] seg;
      bit dark;
      logic [3:0] nib = 4'(m_reg[0] >> (4 * i));
      seg  = m_reg[1][i] ? m_reg[8 + i][6:0] : seg_tab[nib];
      dark = m_reg[2][i] || (m_reg[3][i] && ((cyc / BD) % 2 == 1)) ||
             !((cyc % ((1 << PB) - 1)) < int'(m_reg[4]));
      r[7*i +: 7] = dark ? 7'h7F : ~seg;
    end
    return r;
  endfunction

  // Reference model: registers by address, edge count for blink/PWM timing.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int a = 0; a < 16; a++) m_reg[a] <= 32'h0;
      m_reg[2] <= 32'h3F;
      m_reg[4] <= 32'h3;
      m_cyc    <= 0;
      exp_hex  <= {W{1'b1}};
    end else begin
      exp_hex <= model_hex(m_cyc);
      m_cyc   <= m_cyc + 1;
      if (bus.chipselect && !bus.write_n)
        m_reg[bus.address] <= bus.writedata & reg_mask(bus.address);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(posedge clk); #2;
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(posedge clk); #2;
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic rd(input string name, input logic [3:0] a, input logic [31:0] exp);
    @(posedge clk); #2;
    bus.address = a;
    #2;
    chk(name, 64'(bus.readdata), 64'(exp));
  endtask

  task automatic count_lit(input int digit, input int cycles, output int lit, output int changes);
    logic [6:0] prev;
    lit = 0; changes = 0;
    @(negedge clk); prev = hex_out[7*digit +: 7];
    for (int c = 0; c < cycles; c++) begin
      if (c > 0) @(negedge clk);
      if (hex_out[7*digit +: 7] != 7'h7F) lit++;
      if (hex_out[7*digit +: 7] != prev) changes++;
      prev = hex_out[7*digit +: 7];
    end
  endtask

  initial begin
    logic [W-1:0] e2;
    logic [W-1:0] e3;
    int lit, chg;
    e2 = {7'h40, 7'h40, 7'h08, 7'h10, 7'h00, 7'h40};
    e3 = {7'h40, 7'h40, 7'h08, 7'h10, 7'h00, 7'h36};
    bus.address = 4'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'h0;

    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;

    fork
      forever begin
        @(negedge clk);
        n_cmp++;
        if (hex_out !== exp_hex) begin
          n_fail++;
          $display("FAIL hex_cycle t=%0t: got %h expected %h", $time, hex_out, exp_hex);
        end
        n_cmp++;
        if (bus.readdata !== m_reg[bus.address]) begin
          n_fail++;
          $display("FAIL readdata_cycle addr=%0d: got %h expected %h",
                   bus.address, bus.readdata, m_reg[bus.address]);
        end
      end
    join_none

    // Reset state
    @(posedge clk); #1;
    chk("reset_hex", 64'(hex_out), 64'({W{1'b1}}));
    rd("reset_blank", 4'd2, 32'h3F);
    rd("reset_bright", 4'd4, 32'h3);
    rd("reset_data", 4'd0, 32'h0);

    // Hex decode
    wr(4'd2, 32'h0);
    wr(4'd0, 32'h0000_A980);
    @(posedge clk); #1;
    chk("decode_hex", 64'(hex_out), 64'(e2));
    rd("data_read", 4'd0, 32'h00A980);

    // Raw mode overrides decode
    wr(4'd1, 32'h01);
    wr(4'd8, 32'h49);
    @(posedge clk); #1;
    chk("raw_digit0", 64'(hex_out), 64'(e3));
    wr(4'd0, 32'h0000_A98F);
    @(posedge clk); #1;
    chk("raw_ignores_data", 64'(hex_out), 64'(e3));

    // Field widths and unmapped addresses
    wr(4'd2, 32'hFFFF_FFC0);
    rd("blank_upper_ignored", 4'd2, 32'h0);
    wr(4'd5, 32'hDEAD_BEEF);
    rd("unmapped5", 4'd5, 32'h0);
    wr(4'd14, 32'h7F);
    rd("raw6_unmapped", 4'd14, 32'h0);
    wr(4'd9, 32'hFFFF_FFFF);
    rd("raw1_width", 4'd9, 32'h7F);

    // Blink on digit 1 only
    wr(4'd3, 32'h02);
    repeat (2) @(posedge clk);
    count_lit(1, 16, lit, chg);
    chk("blink_d1_lit", 64'(lit), 64'd8);
    count_lit(0, 16, lit, chg);
    chk("blink_d0_steady", 64'(chg), 64'd0);
    wr(4'd3, 32'h00);

    // PWM brightness
    wr(4'd4, 32'h1);
    repeat (2) @(posedge clk);
    count_lit(0, 12, lit, chg);
    chk("pwm_bright1", 64'(lit), 64'd4);
    wr(4'd4, 32'h0);
    repeat (2) @(posedge clk);
    count_lit(0, 12, lit, chg);
    chk("pwm_bright0", 64'(lit), 64'd0);
    wr(4'd4, 32'h3);
    repeat (2) @(posedge clk);
    count_lit(0, 12, lit, chg);
    chk("pwm_bright3", 64'(lit), 64'd12);

    // Reset mid-blink with a write in flight
    wr(4'd3, 32'h3F);
    repeat (6) @(posedge clk);
    #2;
    bus.address = 4'd0; bus.writedata = 32'h0012_3456;
    bus.chipselect = 1'b1; bus.write_n = 1'b0;
    #1 reset_n = 1'b0;
    #1 chk("async_reset_hex", 64'(hex_out), 64'({W{1'b1}}));
    repeat (2) @(posedge clk);
    #2 bus.chipselect = 1'b0; bus.write_n = 1'b1;
    #1 reset_n = 1'b1;
    rd("post_reset_data", 4'd0, 32'h0);
    rd("post_reset_mode", 4'd1, 32'h0);
    rd("post_reset_blank", 4'd2, 32'h3F);
    rd("post_reset_blink", 4'd3, 32'h0);
    rd("post_reset_bright", 4'd4, 32'h3);
    rd("post_reset_raw0", 4'd8, 32'h0);
    chk("post_reset_hex", 64'(hex_out), 64'({W{1'b1}}));

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
